// File: rtl/drac_pkg.sv
// Shared execution-stage types and constants for the iterative radix-4 multiplier.
package drac_pkg;

    typedef logic [63:0]  bus64_t;
    typedef logic [127:0] bus128_t;

    typedef enum logic [1:0] {
        OpMul    = 2'd0,
        OpMulh   = 2'd1,
        OpMulhsu = 2'd2,
        OpMulhu  = 2'd3
    } mul_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mul_state_t;

    localparam int unsigned MUL_ITER_64 = 32;
    localparam int unsigned MUL_ITER_32 = 16;

endpackage

// File: rtl/mul_2bits.sv
// One radix-4 shift-add step: add multiplicand * multiplier[1:0] into the high accumulator,
// then shift {acc_hi, multiplier} right by two.
module mul_2bits #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned STEP_BITS = 2
) (
    input  logic [XLEN+STEP_BITS-1:0] acc_hi_i,
    input  logic [XLEN-1:0]           multiplier_i,
    input  logic [XLEN-1:0]           multiplicand_i,
    output logic [XLEN+STEP_BITS-1:0] acc_hi_o,
    output logic [XLEN-1:0]           multiplier_o,
    output logic [XLEN-1:0]           multiplicand_o
);

    localparam int unsigned AccW = XLEN + STEP_BITS;

    logic [AccW-1:0] partial;
    logic [AccW-1:0] sum;

    always_comb begin
        partial = {{STEP_BITS{1'b0}}, multiplicand_i} *
                  {{XLEN{1'b0}}, multiplier_i[STEP_BITS-1:0]};
        sum            = acc_hi_i + partial;
        acc_hi_o       = sum >> STEP_BITS;
        // Low bits of the sum drop into the vacated top of the multiplier register.
        multiplier_o   = {sum[STEP_BITS-1:0], multiplier_i[XLEN-1:STEP_BITS]};
        multiplicand_o = multiplicand_i;
    end

endmodule

// File: rtl/mul_iter_2bits.sv
// Iterative radix-4 multiplier for MUL/MULH/MULHSU/MULHU/MULW: magnitudes in, 32 (or 16)
// shift-add steps, sign fix-up and result select on the DONE cycle.
module mul_iter_2bits
    import drac_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned STEP_BITS = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            kill_i,
    input  logic            request_i,
    input  logic [1:0]      op_i,
    input  logic            int_32_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o
);

    localparam int unsigned AccW = XLEN + STEP_BITS;
    localparam logic [4:0] CntLoad64 = 5'(MUL_ITER_64 - 1);
    localparam logic [4:0] CntLoad32 = 5'(MUL_ITER_32 - 1);

    mul_state_t      state_q, state_d;
    mul_op_t         op_q, op_d;
    logic            w_q, w_d;
    logic            sign_q, sign_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [AccW-1:0] step_acc;
    logic [XLEN-1:0] step_mplier;
    logic [XLEN-1:0] step_mcand;

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic            a_signed, b_signed, a_neg, b_neg;
    bus128_t         prod, prod_s;
    logic [XLEN-1:0] res;
    logic            unused_acc_top;

    mul_2bits #(
        .XLEN      (XLEN),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .acc_hi_i       (acc_q),
        .multiplier_i   (mplier_q),
        .multiplicand_i (mcand_q),
        .acc_hi_o       (step_acc),
        .multiplier_o   (step_mplier),
        .multiplicand_o (step_mcand)
    );

    // Entry: W forms sign-extend from bit 31 and always behave as signed MULW.
    always_comb begin
        a_ext    = int_32_i ? {{32{src1_i[31]}}, src1_i[31:0]} : src1_i;
        b_ext    = int_32_i ? {{32{src2_i[31]}}, src2_i[31:0]} : src2_i;
        a_signed = int_32_i || (op_i != OpMulhu);
        b_signed = int_32_i || (op_i == OpMul) || (op_i == OpMulh);
        a_neg    = a_signed && a_ext[XLEN-1];
        b_neg    = b_signed && b_ext[XLEN-1];
        a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    end

    // After 16 W steps the 64-bit product sits 32 bits higher in {acc, multiplier}.
    always_comb begin
        if (w_q) begin
            prod = {64'd0, acc_q[31:0], mplier_q[XLEN-1:32]};
        end else begin
            prod = {acc_q[XLEN-1:0], mplier_q};
        end
        prod_s = sign_q ? (~prod + 128'd1) : prod;
        if (w_q) begin
            res = {{32{prod_s[31]}}, prod_s[31:0]};
        end else if (op_q == OpMul) begin
            res = prod_s[63:0];
        end else begin
            res = prod_s[127:64];
        end
    end

    assign unused_acc_top = ^acc_q[AccW-1:XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        w_d      = w_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (!kill_i && request_i) begin
                    state_d  = StBusy;
                    op_d     = int_32_i ? OpMul : mul_op_t'(op_i);
                    w_d      = int_32_i;
                    sign_d   = a_neg ^ b_neg;
                    cnt_d    = int_32_i ? CntLoad32 : CntLoad64;
                    acc_d    = '0;
                    mplier_d = b_mag;
                    mcand_d  = a_mag;
                end
            end
            StBusy: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = step_acc;
                    mplier_d = step_mplier;
                    mcand_d  = step_mcand;
                    cnt_d    = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!kill_i) begin
                    result_d = res;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            w_q      <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            w_q      <= w_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

    assign result_o = (state_q == StDone) ? res : result_q;
    assign ready_o  = (state_q == StDone) && !kill_i;
    assign busy_o   = (state_q != StIdle);

endmodule
